// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// stream framing constants and the byte-insertion helper.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int DATA_W = 32;
    localparam bit BIG_ENDIAN = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LEN_HI = ST_LEN_HI,
        S_LEN_LO = ST_LEN_LO,
        S_DATA   = ST_DATA,
        S_WRITE  = ST_WRITE,
        S_DONE   = ST_DONE,
        S_ERR    = ST_ERR
    } state_t;

    // Big-endian: earlier bytes migrate toward bit 31 as later bytes arrive.
    function automatic logic [DATA_W-1:0] shift_byte(input logic [DATA_W-1:0] w,
                                                     input logic [7:0]        b);
        if (BIG_ENDIAN) begin
            shift_byte = {w[DATA_W-9:0], b};
        end else begin
            shift_byte = {b, w[DATA_W-1:8]};
        end
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into one instruction word; word_full_o flags the
// shift that completes the word (byte counter wrapping 3 -> 0).
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic [7:0]        byte_in_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_full_o
);
    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;

    // Next-state for the partial word and byte position.
    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (clr_i) begin
            word_d     = {DATA_W{1'b0}};
            byte_cnt_d = 2'd0;
        end else if (shift_en_i) begin
            word_d     = shift_byte(word_q, byte_in_i);
            byte_cnt_d = byte_cnt_q + 2'd1;
        end else begin
            word_d     = word_q;
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Partial word and byte counter survive source stalls untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q     <= {DATA_W{1'b0}};
            byte_cnt_q <= 2'd0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_en_i && !clr_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory from
// address 0, then releases the datapath from hold.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt_q;
    logic              in_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [DATA_W-1:0] im_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic              accept_s;
    logic              shift_en_s;
    logic              restart_s;
    logic [LEN_W-1:0]  len_full_s;
    logic              len_bad_s;
    logic              last_s;
    logic [DATA_W-1:0] word_s;
    logic              word_full_s;

    assign accept_s   = bus.in_valid && in_ready_q;
    assign shift_en_s = accept_s && (state_q == S_DATA);
    assign restart_s  = bus.start &&
                        ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign len_full_s = {len_q[LEN_W-1:8], bus.in_data};
    assign len_bad_s  = (len_full_s == {LEN_W{1'b0}}) || (len_full_s > DEPTH);
    assign last_s     = (word_cnt_q == (len_q - 16'd1));

    word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (shift_en_s),
        .byte_in_i   (bus.in_data),
        .clr_i       (restart_s),
        .word_o      (word_s),
        .word_full_o (word_full_s)
    );

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= {LEN_W{1'b0}};
            word_cnt_q <= {LEN_W{1'b0}};
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= {ADDR_W{1'b0}};
            im_wdata_q <= {DATA_W{1'b0}};
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (restart_s) begin
                        state_q    <= S_LEN_HI;
                        in_ready_q <= 1'b1;
                        word_cnt_q <= {LEN_W{1'b0}};
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end else if (state_q == S_DONE) begin
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else if (state_q == S_ERR) begin
                        err_q      <= 1'b1;
                        cpu_hold_q <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (accept_s) begin
                        len_q[LEN_W-1:8] <= bus.in_data;
                        state_q          <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept_s) begin
                        len_q[7:0] <= bus.in_data;
                        if (len_bad_s) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_full_s) begin
                        state_q    <= S_WRITE;
                        in_ready_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    // len never exceeds DEPTH, so the address slice cannot wrap.
                    im_we_q    <= 1'b1;
                    im_addr_q  <= word_cnt_q[ADDR_W-1:0];
                    im_wdata_q <= word_s;
                    if (last_s) begin
                        state_q    <= S_DONE;
                    end else begin
                        word_cnt_q <= word_cnt_q + 16'd1;
                        state_q    <= S_DATA;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, corner sequences and
// randomized loads compared against a simple expected-write model.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]        byte_q[$];
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap_at;
        int          gap_len;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;
    vec_t vecs[6];

    // Memory-side monitor: im_we is high for whole cycles, so one sample per pulse.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_addr_q.push_back(bus.im_addr);
            wr_data_q.push_back(bus.im_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic header(input logic [15:0] len);
        byte_q.delete();
        byte_q.push_back(len[15:8]);
        byte_q.push_back(len[7:0]);
    endtask

    task automatic add_word(input logic [31:0] w);
        byte_q.push_back(w[31:24]);
        byte_q.push_back(w[23:16]);
        byte_q.push_back(w[15:8]);
        byte_q.push_back(w[7:0]);
    endtask

    // Offers each byte until accepted; returns right after the last accepting edge.
    task automatic send_stream(input int gap_at, input int gap_len, input int rnd_max);
        for (int i = 0; i < byte_q.size(); i++) begin
            int n_gap;
            int budget;
            bit acc;
            n_gap = (i == gap_at) ? gap_len : 0;
            if (rnd_max > 0) n_gap += int'($urandom_range(0, rnd_max));
            repeat (n_gap) begin
                @(negedge clk); bus.in_valid = 1'b0;
            end
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 64) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = byte_q[i];
                acc = bus.in_ready;
                budget++;
                @(posedge clk);
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout byte %0d: in_ready stayed 0, required 1", i);
                return;
            end
        end
    endtask

    task automatic finish_ok(input string tag);
        @(negedge clk); bus.in_valid = 1'b0;
        chk({tag, "_rdy_in_write"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_done_early1"}, 32'(bus.done), 32'd0);
        @(negedge clk);
        chk({tag, "_last_we"}, 32'(bus.im_we), 32'd1);
        chk({tag, "_done_early2"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold_early"}, 32'(bus.cpu_hold), 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_hold_rel"}, 32'(bus.cpu_hold), 32'd0);
        chk({tag, "_no_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic finish_err(input string tag);
        @(negedge clk); bus.in_valid = 1'b0;
        chk({tag, "_rdy_err"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_err"}, 32'(bus.err), 32'd1);
        chk({tag, "_err_hold"}, 32'(bus.cpu_hold), 32'd1);
        chk({tag, "_err_done"}, 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_err_level"}, 32'(bus.err), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < wr_addr_q.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(wr_addr_q[k]), 32'(k));
            chk($sformatf("%s_data%0d", tag, k), wr_data_q[k], exp_q[k]);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{16'h0002, 32'h20080005, 32'h01095020, -1, 0, 1'b0, 2};
        vecs[1] = '{16'h0002, 32'h20080005, 32'h01095020,  4, 3, 1'b0, 2};
        vecs[2] = '{16'h0000, 32'h0,        32'h0,        -1, 0, 1'b1, 0};
        vecs[3] = '{16'h0021, 32'h0,        32'h0,        -1, 0, 1'b1, 0};
        vecs[4] = '{16'h0001, 32'hDEADBEEF, 32'h0,         3, 1, 1'b0, 1};
        vecs[5] = '{16'h0100, 32'h0,        32'h0,        -1, 0, 1'b1, 0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_im_we",    32'(bus.im_we),    32'd0);
        chk("rst_im_addr",  32'(bus.im_addr),  32'd0);
        chk("rst_im_wdata", bus.im_wdata,      32'd0);
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_err",      32'(bus.err),      32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", 32'(bus.in_ready), 32'd0);

        for (int i = 0; i < 6; i++) begin
            wr_addr_q.delete(); wr_data_q.delete(); exp_q.delete();
            header(vecs[i].len);
            if (!vecs[i].exp_err) begin
                add_word(vecs[i].w0);
                if (vecs[i].len > 16'd1) add_word(vecs[i].w1);
            end
            for (int k = 0; k < vecs[i].exp_nwr; k++)
                exp_q.push_back((k == 0) ? vecs[i].w0 : vecs[i].w1);
            start_pulse();
            send_stream(vecs[i].gap_at, vecs[i].gap_len, 0);
            if (vecs[i].exp_err) finish_err($sformatf("v%0d", i));
            else                 finish_ok($sformatf("v%0d", i));
            check_writes($sformatf("v%0d", i));
        end

        // Full depth: the last write must land on address 31.
        wr_addr_q.delete(); wr_data_q.delete(); exp_q.delete();
        header(16'd32);
        for (int k = 0; k < DEPTH; k++) begin
            add_word(32'(k));
            exp_q.push_back(32'(k));
        end
        start_pulse();
        send_stream(-1, 0, 0);
        finish_ok("full");
        check_writes("full");
        if (wr_addr_q.size() == DEPTH) chk("full_last_addr", 32'(wr_addr_q[DEPTH-1]), 32'd31);
        else chk("full_size", 32'(wr_addr_q.size()), 32'(DEPTH));

        // Reset mid-word, then a fresh one-word load.
        wr_addr_q.delete(); wr_data_q.delete(); exp_q.delete();
        header(16'd1);
        byte_q.push_back(8'hAA);
        byte_q.push_back(8'hBB);
        start_pulse();
        send_stream(-1, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_hold",  32'(bus.cpu_hold), 32'd1);
        chk("mid_rst_we",    32'(bus.im_we),    32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_idle", 32'(bus.in_ready), 32'd0);
        header(16'd1);
        add_word(32'h11223344);
        exp_q.push_back(32'h11223344);
        start_pulse();
        send_stream(-1, 0, 0);
        finish_ok("after_rst");
        check_writes("after_rst");

        // Reload from DONE.
        wr_addr_q.delete(); wr_data_q.delete(); exp_q.delete();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        chk("reload_done_drop", 32'(bus.done),     32'd0);
        chk("reload_hold_rise", 32'(bus.cpu_hold), 32'd1);
        chk("reload_ready",     32'(bus.in_ready), 32'd1);
        header(16'd1);
        add_word(32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D);
        send_stream(-1, 0, 0);
        finish_ok("reload");
        check_writes("reload");

        // Randomized loads with stalls; model: legal len writes words 0..len-1 in order.
        for (int r = 0; r < 8; r++) begin
            logic [15:0] len;
            bit          legal;
            logic [31:0] w;
            wr_addr_q.delete(); wr_data_q.delete(); exp_q.delete();
            len = 16'($urandom_range(0, 34));
            if ($urandom_range(0, 3) != 0) len = 16'($urandom_range(1, DEPTH));
            legal = (len >= 16'd1) && (len <= 16'(DEPTH));
            header(len);
            if (legal) begin
                for (int k = 0; k < int'(len); k++) begin
                    w = $urandom;
                    add_word(w);
                    exp_q.push_back(w);
                end
            end
            start_pulse();
            send_stream(-1, 0, 2);
            if (legal) finish_ok($sformatf("rnd%0d", r));
            else       finish_err($sformatf("rnd%0d", r));
            check_writes($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
